// File: rtl/serial_incr_ctrl.sv
// -----------------------------------------------------------------------------
// serial_incr_ctrl
//
// Bit-serial increment stage. A parallel WIDTH-bit operand is captured, then
// streamed LSB-first through a one-bit half adder whose carry input starts at
// 1. A carry flip-flop ripples the carry from bit to bit, and each sum bit is
// shifted back in at the MSB end. After exactly WIDTH shift cycles, the shift
// register holds in_data + 1 (mod 2^WIDTH). It is then presented as a
// parallel result.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_valid   in   upstream word valid
//   in_ready   out  block can accept a word (IDLE only)
//   in_data    in   WIDTH-bit operand
//   out_valid  out  result valid (DONE only)
//   out_ready  in   downstream accepts result
//   out_data   out  in_data + 1, modulo 2^WIDTH
//   out_ovf    out  final carry out (operand was all ones)
//   ser_bit    out  operand bit currently presented to the half adder
//   ser_valid  out  high while ser_bit is meaningful (SHIFT state)
//
// All outputs are registered. Each output register is loaded from the
// next-state decode, so it always reflects the state it is entering.
// -----------------------------------------------------------------------------
module serial_incr_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             ser_bit,
  output logic             ser_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] sr_s;
  logic             carry_r;
  logic             carry_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_s;
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] out_data_s;
  logic             out_ovf_r;
  logic             out_ovf_s;
  logic             in_ready_r;
  logic             in_ready_s;
  logic             out_valid_r;
  logic             out_valid_s;
  logic             ser_valid_r;
  logic             ser_valid_s;
  logic             ser_bit_r;
  logic             ser_bit_s;
  logic             sum_s;
  logic             cout_s;
  logic             last_s;
  logic [WIDTH-1:0] shifted_s;

  // One-bit half adder: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  // Serial datapath: the half adder on the current LSB plus the carry
  // flip-flop. Once the carry is 0 it stays 0, so the upper bits pass through.
  always_comb begin
    {cout_s, sum_s} = half_add(sr_r[0], carry_r);
    shifted_s       = {sum_s, sr_r[WIDTH-1:1]};
    last_s          = (count_r == CW'(WIDTH - 1));
  end

  // Next-state and datapath-update decode.
  always_comb begin
    state_s    = state_r;
    sr_s       = sr_r;
    carry_s    = carry_r;
    count_s    = count_r;
    out_data_s = out_data_r;
    out_ovf_s  = out_ovf_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_s = SHIFT;
          sr_s    = in_data;
          carry_s = 1'b1;
          count_s = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        sr_s    = shifted_s;
        carry_s = cout_s;
        count_s = count_r + CW'(1);
        // The last shift also captures the finished word into the
        // result register, so out_data is stable for the whole DONE state.
        if (last_s) begin
          state_s    = DONE;
          out_data_s = shifted_s;
          out_ovf_s  = cout_s;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        sr_s    = {WIDTH{1'b0}};
        carry_s = 1'b1;
        count_s = {CW{1'b0}};
      end
    endcase
  end

  // Output decode from the state being entered, so the output flops line up
  // with the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    ser_valid_s = 1'b0;
    ser_bit_s   = 1'b0;
    case (state_s)
      IDLE: begin
        in_ready_s = 1'b1;
      end
      SHIFT: begin
        ser_valid_s = 1'b1;
        ser_bit_s   = sr_s[0];
      end
      DONE: begin
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // FSM state, shift register, carry and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      sr_r    <= {WIDTH{1'b0}};
      carry_r <= 1'b1;
      count_r <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      sr_r    <= sr_s;
      carry_r <= carry_s;
      count_r <= count_s;
    end
  end

  // Registered result word and overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_r <= {WIDTH{1'b0}};
      out_ovf_r  <= 1'b0;
    end else begin
      out_data_r <= out_data_s;
      out_ovf_r  <= out_ovf_s;
    end
  end

  // Registered handshake and serial-tap outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      ser_valid_r <= 1'b0;
      ser_bit_r   <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      ser_valid_r <= ser_valid_s;
      ser_bit_r   <= ser_bit_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;
  assign ser_valid = ser_valid_r;
  assign ser_bit   = ser_bit_r;

endmodule

// File: tb/tb_serial_incr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_incr_ctrl
//
// Scoreboard bench for serial_incr_ctrl (WIDTH=8). The stimulus process
// issues words. The monitor, which runs on the falling edge, records every
// accepted word together with the cycle of its accept edge. From those two
// facts it derives what the DUT must show:
//   - the serial bit stream during the following WIDTH cycles,
//   - out_valid from accept+WIDTH onward,
//   - the result (d+1) mod 256 and the carry-out flag (d == 0xFF).
// -----------------------------------------------------------------------------
module tb_serial_incr_ctrl;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             ser_bit;
  logic             ser_valid;

  serial_incr_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    int               a;   // cycle number of the accept edge
  } item_t;

  item_t q[$];
  int    cyc   = 0;
  int    vecs  = 0;
  int    errs  = 0;
  int    ordy_mode = 1;    // 0: out_ready low, 1: high, 2: random

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic void timeout(string nm);
    vecs++;
    errs++;
    $display("FAIL timeout_%s: got no response expected handshake at cycle %0d", nm, cyc);
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
      chk("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
      chk("rst_ser_bit", {31'd0, ser_bit}, 32'd0);
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() == 0)});
      if (q.size() != 0) begin
        item_t it;
        logic  sh;
        logic  dv;
        it = q[0];
        sh = (cyc >= it.a) && (cyc < it.a + WIDTH);
        dv = (cyc >= it.a + WIDTH);
        chk("ser_valid", {31'd0, ser_valid}, {31'd0, sh});
        if (sh) chk("ser_bit", {31'd0, ser_bit}, {31'd0, it.d[cyc - it.a]});
        chk("out_valid", {31'd0, out_valid}, {31'd0, dv});
        if (dv && out_valid) begin
          chk("out_data", {24'd0, out_data}, (32'(it.d) + 32'd1) % 32'd256);
          chk("out_ovf", {31'd0, out_ovf}, {31'd0, (it.d == 8'hFF)});
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
        chk("ser_valid_idle", {31'd0, ser_valid}, 32'd0);
      end
      if (in_valid && in_ready) begin
        item_t ni;
        ni.d = in_data;
        ni.a = cyc + 1;
        q.push_back(ni);
      end
    end
  end

  // Downstream out_ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Present a word and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        timeout("accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
  endtask

  // Wait until every accepted word has been handed downstream.
  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        timeout("drain");
        q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] d;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset held for three cycles; released just after an edge so the very
    // next edge can accept the first word.
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(8'h2A);
    wait_drain();

    // Wrap-around and early-carry words.
    send(8'hFF);
    send(8'h7F);
    wait_drain();

    // Downstream stall: result held, a busy block refuses the next word.
    ordy_mode = 0;
    @(posedge clk);
    #1;
    send(8'h10);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout("stall_valid");
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    ordy_mode = 1;
    send(8'h55);
    wait_drain();

    // Reset asserted at SHIFT cycle 4 discards the word in flight.
    send(8'h0F);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(8'h01);
    wait_drain();

    // Back-to-back stream with out_ready held high.
    send(8'h00);
    send(8'h01);
    send(8'hFE);
    wait_drain();

    // Randomized traffic with random gaps and random back-pressure.
    ordy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       d = 8'hFF;
        1:       d = 8'h7F;
        2:       d = 8'h00;
        default: d = WIDTH'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(d);
    end
    ordy_mode = 1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
